imm_materializer: RTL
=====================

# imm_materializer

Inverse of the ID-stage immediate decoder. It takes a 64-bit constant and a destination register and emits the RV64I instruction sequence that builds that constant in the register. The sequence is LUI/ADDI/ADDIW/SLLI, and each immediate is encoded so the decoder reproduces it exactly. Consumers are the debug-module program buffer and boot-stub injection at the fetch/decode boundary, both via a valid/ready stream.

## Interface
- No parameters.
- clk_i  in  1  core clock.
- rstn_i  in  1  asynchronous reset, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block idle, request can be accepted.
- req_value_i  in  64  constant to materialize.
- req_rd_i  in  5  destination register.
- instr_valid_o  out  1  instr_o holds a valid instruction word.
- instr_ready_i  in  1  consumer accepts instr_o.
- instr_o  out  32  encoded instruction.
- instr_last_o  out  1  current word is the final one of the sequence.
- busy_o  out  1  sequence in progress (state != IDLE).

## Operation
- FSM states:
  - IDLE: req_ready_o=1.
  - EMIT: step counter 0..N-1.
- On accept (req_valid_i & req_ready_o), latch value v and rd, select mode and N, enter EMIT at step 0.
- Mode selection, evaluated in this order:
  - SHORT (N=1) when v[63:11] are all equal. Emit ADDI rd,x0,v[11:0].
  - MEDIUM (N=2) when v[63:31] are all equal:
    - hi20 = (v[31:12]+v[11]) mod 2^20, lo12 = v[11:0].
    - Emit LUI rd,hi20; ADDIW rd,rd,lo12.
  - LONG (N=8):
    - hi20 = (v[63:44]+v[43]) mod 2^20, lo12 = v[43:32].
    - Emit LUI rd,hi20; ADDIW rd,rd,lo12; SLLI rd,rd,11; ADDI rd,rd,{0,v[31:21]}; SLLI rd,rd,11; ADDI rd,rd,{0,v[20:10]}; SLLI rd,rd,10; ADDI rd,rd,{00,v[9:0]}.
    - Chunk immediates have bit11=0, so they are non-negative.
- Encodings use the standard RV64I formats:
  - LUI: opcode 0110111.
  - ADDI: opcode 0010011, funct3 000.
  - SLLI: opcode 0010011, funct3 001, funct6 000000, shamt[5:0] at [25:20].
  - ADDIW: opcode 0011011, funct3 000.
- rd=x0: handled by the normal rules (harmless writes to x0). v=0 with any rd is SHORT.
- All arithmetic is mod 2^64. The carry increment on hi20 wraps silently; ADDIW's 32-bit wrap absorbs it.

## Timing
- Reset values:
  - State IDLE, step counter 0.
  - req_ready_o=1.
  - instr_valid_o=0, instr_o=0, instr_last_o=0, busy_o=0.
  - Latched value and rd 0.
- Output latency:
  - The accept cycle is cycle 0; the first word is valid at cycle 1.
  - instr_o is derived combinationally from registered state only; there is no input-to-output combinational path.
- Handshake and stability:
  - A word transfers when instr_valid_o & instr_ready_i.
  - While instr_valid_o=1 and instr_ready_i=0, instr_o, instr_last_o and the step counter hold.
  - instr_valid_o never drops before transfer.
- End of sequence:
  - After the last transfer, the next cycle is IDLE with req_ready_o=1.
  - No same-cycle re-accept, so minimum request period is N+1 cycles.
- While busy, req_ready_o=0 and req_valid_i is ignored; the upstream must hold its request.
- Async reset mid-sequence aborts immediately: all outputs go to reset values, no partial sequence resumes.

## Structure
- Opcode/funct3 constants come from riscv_pkg (OP_LUI, OP_ALU_I, OP_ALU_I_W, F3_SLLI, ADDI/ADDIW funct3).
- Add these to drac_pkg:
  - imm_mat_mode_t {SHORT, MEDIUM, LONG}.
  - imm_mat_state_t {IDLE, EMIT}.
- One natural sub-module: imm_mat_encoder. It is combinational: (mode, step, v, rd) → instr_o, last.
- The FSM, latches and counter stay in the top.

## Test plan
- SHORT: v=0x5, rd=5. One beat 0x00500293 with last=1; req_ready_o high the cycle after.
- SHORT negative: v=0xFFFFFFFFFFFFF800, rd=1. One beat 0x80000093, last=1.
- MEDIUM carry: v=0x12345FFF, rd=10. Beats 0x12346537 then 0xFFF5051B; last on beat 2.
- LONG: v=0x0000000100000000, rd=2, instr_ready_i held 1.
  - Beats, one per cycle, last only on the 8th: 0x00000137, 0x0011011B, 0x00B11113, 0x00010113, 0x00B11113, 0x00010113, 0x00A11113, 0x00010113.
- Backpressure: the LONG case with instr_ready_i=0 for 3 cycles at step 3.
  - instr_o stays 0x00010113 and valid stays high.
  - req_ready_o=0 throughout, and a new req_valid_i is not accepted.
- Reset mid-sequence: assert rstn_i=0 at step 4 of LONG.
  - Outputs go to 0 and req_ready_o=1 asynchronously.
  - The next request (v=0x5) produces a clean single beat.

Source files
------------

// File: rtl/imm_materializer_pkg.sv
// Shared RV64I encoding constants, materializer mode/state types and word-format helpers.
// Pure declarations; no state, no latency.
// No flow control of its own.
package imm_materializer_pkg;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_ALU_I   = 7'b0010011;
    localparam logic [6:0] OP_ALU_I_W = 7'b0011011;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_ADDIW   = 3'b000;
    localparam logic [2:0] F3_SLLI    = 3'b001;

    typedef enum logic [1:0] {SHORT, MEDIUM, LONG} imm_mat_mode_t;
    typedef enum logic       {IDLE, EMIT}          imm_mat_state_t;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_slli(input logic [5:0] shamt, input logic [4:0] rd);
        return {6'b000000, shamt, rd, F3_SLLI, rd, OP_ALU_I};
    endfunction

    // A value fits an N-bit signed immediate when all bits from the sign bit upward agree.
    function automatic imm_mat_mode_t select_mode(input logic [63:0] v);
        if ((&v[63:11]) || !(|v[63:11]))
            return SHORT;
        else if ((&v[63:31]) || !(|v[63:31]))
            return MEDIUM;
        else
            return LONG;
    endfunction

endpackage

// File: rtl/imm_mat_encoder.sv
// Combinational encoder: (mode, step, value, rd) -> instruction word and last flag.
// Zero latency.
// No flow control; the caller holds inputs stable while a word is stalled.
module imm_mat_encoder
    import imm_materializer_pkg::*;
(
    input  imm_mat_mode_t mode,
    input  logic [2:0]    step,
    input  logic [63:0]   v,
    input  logic [4:0]    rd,
    output logic [31:0]   instr,
    output logic          last
);

    logic [19:0] hi_med;
    logic [19:0] hi_long;

    // LUI is sign-extended and ADDIW adds a signed low part, so round hi20 up when bit 11/43 is set.
    assign hi_med  = v[31:12] + {19'd0, v[11]};
    assign hi_long = v[63:44] + {19'd0, v[43]};

    always_comb begin
        instr = '0;
        last  = 1'b0;
        case (mode)
            SHORT: begin
                instr = enc_i(v[11:0], 5'd0, F3_ADDI, rd, OP_ALU_I);
                last  = 1'b1;
            end
            MEDIUM: begin
                if (step == 3'd0)
                    instr = enc_u(hi_med, rd, OP_LUI);
                else
                    instr = enc_i(v[11:0], rd, F3_ADDIW, rd, OP_ALU_I_W);
                last = (step == 3'd1);
            end
            default: begin
                case (step)
                    3'd0:    instr = enc_u(hi_long, rd, OP_LUI);
                    3'd1:    instr = enc_i(v[43:32], rd, F3_ADDIW, rd, OP_ALU_I_W);
                    3'd2:    instr = enc_slli(6'd11, rd);
                    3'd3:    instr = enc_i({1'b0, v[31:21]}, rd, F3_ADDI, rd, OP_ALU_I);
                    3'd4:    instr = enc_slli(6'd11, rd);
                    3'd5:    instr = enc_i({1'b0, v[20:10]}, rd, F3_ADDI, rd, OP_ALU_I);
                    3'd6:    instr = enc_slli(6'd10, rd);
                    default: instr = enc_i({2'b00, v[9:0]}, rd, F3_ADDI, rd, OP_ALU_I);
                endcase
                last = (step == 3'd7);
            end
        endcase
    end

endmodule

// File: rtl/imm_materializer.sv
// Turns a 64-bit constant + rd into an LUI/ADDI/ADDIW/SLLI stream that rebuilds it.
// First word valid the cycle after accept; one word per cycle while instr_ready_i is high.
// Single request in flight: req_ready_o low until the last word transfers; stalled words hold.
module imm_materializer
    import imm_materializer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] req_value_i,
    input  logic [4:0]  req_rd_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_last_o,
    output logic        busy_o
);

    imm_mat_state_t state;
    imm_mat_mode_t  mode;
    logic [2:0]     step;
    logic [63:0]    val;
    logic [4:0]     rd;
    logic [31:0]    enc_instr;
    logic           enc_last;

    imm_mat_encoder u_encoder (
        .mode  (mode),
        .step  (step),
        .v     (val),
        .rd    (rd),
        .instr (enc_instr),
        .last  (enc_last)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            mode  <= SHORT;
            step  <= 3'd0;
            val   <= '0;
            rd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        val   <= req_value_i;
                        rd    <= req_rd_i;
                        mode  <= select_mode(req_value_i);
                        step  <= 3'd0;
                        state <= EMIT;
                    end
                end
                default: begin
                    if (instr_ready_i) begin
                        if (enc_last) begin
                            step  <= 3'd0;
                            state <= IDLE;
                        end else begin
                            step  <= step + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy_o        = (state == EMIT);
    assign req_ready_o   = (state == IDLE);
    assign instr_valid_o = busy_o;
    // Gate the encoder so idle outputs read as zero.
    assign instr_o       = busy_o ? enc_instr : 32'd0;
    assign instr_last_o  = busy_o & enc_last;

endmodule
